id_to_ex_register: RTL and testbench
====================================

# id_to_ex_register

ID/EX pipeline register of the five-stage core. Captures decoded operands and control signals from the decode stage each cycle and presents them to the execute stage. Converts a decode-stage stall (from the hazard handler) or a branch flush into a bubble, and drives the registered write-back/load controls that the hazard handler checks. Also keeps a saturating bubble counter for performance measurement.

## Interface
Parameters:
- CNT_WIDTH, 16, width of the bubble counter.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  asynchronous, active-high reset.
- stall_ctrl_i  input  1  hazard-handler stall; the instruction now in decode must not enter EX this cycle.
- flush_ctrl_i  input  1  taken-branch flush; the instruction in decode is squashed.
- cnt_clr_i  input  1  synchronous clear of the bubble counter.
- pc_plus4_i  input  32  PC+4 of the decode instruction.
- rs_data_i, rt_data_i  input  32 each  register-file read data (forwarded if applicable).
- immed_i  input  32  sign-extended immediate.
- rs_addr_i, rt_addr_i, rd_addr_i  input  5 each  register addresses.
- reg_dst_ctrl_i  input  1  destination select: 1 = rd, 0 = rt.
- reg_write_ctrl_i, mem_read_ctrl_i, mem_write_ctrl_i, mem_to_reg_ctrl_i, alu_src_ctrl_i  input  1 each  decoded controls.
- alu_op_ctrl_i  input  3  ALU operation.
- pc_plus4_o, rs_data_o, rt_data_o, immed_o  output  32 each  registered copies.
- rs_addr_o, rt_addr_o  output  5 each  registered source addresses (for EX forwarding).
- reg_write_addr_o  output  5  registered destination address.
- reg_write_ctrl_o, mem_read_ctrl_o, mem_write_ctrl_o, mem_to_reg_ctrl_o, alu_src_ctrl_o  output  1 each.
- alu_op_ctrl_o  output  3.
- valid_o  output  1  1 = EX holds a real instruction, 0 = bubble.
- bubble_cnt_o  output  CNT_WIDTH  number of bubbles inserted since reset/clear.

## Operation
- Destination select before capture: dest = reg_dst_ctrl_i ? rd_addr_i : rt_addr_i.
- $0 rule: if dest == 0, the captured reg_write_ctrl and mem_read_ctrl are forced to 0. Loads to $0 and writes to $0 never appear as hazards downstream.
- Bubble condition: bubble = stall_ctrl_i | flush_ctrl_i.
- Normal capture (bubble = 0):
  - all data, address and control fields load from inputs, with the $0 rule applied;
  - valid_o <= 1.
- Bubble capture (bubble = 1):
  - reg_write, mem_read, mem_write, mem_to_reg, alu_src cleared to 0; alu_op_ctrl_o <= 0;
  - reg_write_addr_o <= 0, valid_o <= 0;
  - data fields (pc_plus4, rs/rt data, immed, rs/rt addr) still load from inputs. Their values are don't-care but must be deterministic.
- This block does not hold its own contents on stall. Holding PC and IF/ID is the upstream registers' job; ID/EX always advances.
- Bubble counter:
  - cnt_clr_i has priority: counter <= 0 that cycle, even if a bubble is also inserted;
  - otherwise counter increments by 1 per bubble cycle;
  - counter saturates at all-ones and does not wrap;
  - stall and flush asserted together count as one bubble.

## Timing
- Latency is one cycle. Inputs sampled at rising edge N appear on outputs after edge N and stay stable until edge N+1.
- All outputs are registered; there is no combinational input-to-output path.
- Reset (asynchronous, on rst_i rising, independent of clk_i): every output goes to 0, including valid_o = 0 and bubble_cnt_o = 0. The pipeline therefore starts with a bubble in EX.
- Reset asserted mid-operation: outputs clear immediately. The first edge after rst_i deasserts performs a normal capture.
- Back-to-back stalls: one bubble per cycle; the counter increments each cycle.
- A load followed by a dependent instruction produces exactly one bubble in this register (the hazard handler stalls for one cycle).

## Test plan
- Reset: drive all inputs nonzero and assert rst_i between clock edges -> every output reads 0 immediately, before the next edge.
- Normal capture: reg_dst=1, rd=5, rt=7, reg_write=1, alu_op=3'b010, rs_data=0x1234 -> next cycle reg_write_addr_o=5, reg_write_ctrl_o=1, alu_op_ctrl_o=2, rs_data_o=0x1234, valid_o=1. Repeat with reg_dst=0 -> reg_write_addr_o=7.
- Stall bubble: a load (mem_read=1, rt=9, reg_dst=0) is captured, then stall_ctrl_i=1 for one cycle with a dependent instruction at the inputs -> outputs show mem_read=1, addr 9, valid 1; then all controls 0, addr 0, valid 0; bubble_cnt_o=1. The dependent instruction is captured on the following cycle.
- $0 rule: reg_write=1, mem_read=1, reg_dst=0, rt=0 -> reg_write_ctrl_o=0, mem_read_ctrl_o=0, reg_write_addr_o=0, valid_o=1.
- Stall and flush together for 3 cycles -> 3 bubbles, bubble_cnt_o increases by exactly 3.
- Counter saturation with CNT_WIDTH=4: hold stall for 20 cycles -> bubble_cnt_o stops at 15. Then cnt_clr_i=1 with stall=1 -> counter reads 0; next bubble cycle -> 1.

Source files
------------

// File: rtl/id_to_ex_register.sv
// ID/EX pipeline register: captures decoded operands/controls, turns
// stall or flush into a bubble, and counts inserted bubbles (saturating).
module id_to_ex_register #(
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_ctrl_i,
  input  logic                 flush_ctrl_i,
  input  logic                 cnt_clr_i,
  input  logic [31:0]          pc_plus4_i,
  input  logic [31:0]          rs_data_i,
  input  logic [31:0]          rt_data_i,
  input  logic [31:0]          immed_i,
  input  logic [4:0]           rs_addr_i,
  input  logic [4:0]           rt_addr_i,
  input  logic [4:0]           rd_addr_i,
  input  logic                 reg_dst_ctrl_i,
  input  logic                 reg_write_ctrl_i,
  input  logic                 mem_read_ctrl_i,
  input  logic                 mem_write_ctrl_i,
  input  logic                 mem_to_reg_ctrl_i,
  input  logic                 alu_src_ctrl_i,
  input  logic [2:0]           alu_op_ctrl_i,
  output logic [31:0]          pc_plus4_o,
  output logic [31:0]          rs_data_o,
  output logic [31:0]          rt_data_o,
  output logic [31:0]          immed_o,
  output logic [4:0]           rs_addr_o,
  output logic [4:0]           rt_addr_o,
  output logic [4:0]           reg_write_addr_o,
  output logic                 reg_write_ctrl_o,
  output logic                 mem_read_ctrl_o,
  output logic                 mem_write_ctrl_o,
  output logic                 mem_to_reg_ctrl_o,
  output logic                 alu_src_ctrl_o,
  output logic [2:0]           alu_op_ctrl_o,
  output logic                 valid_o,
  output logic [CNT_WIDTH-1:0] bubble_cnt_o
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [4:0] dest;
  logic       dest_is_zero;
  logic       bubble;

  // Destination select and bubble decode ahead of capture
  always_comb begin
    dest         = reg_dst_ctrl_i ? rd_addr_i : rt_addr_i;
    dest_is_zero = (dest == 5'd0);
    bubble       = stall_ctrl_i | flush_ctrl_i;
  end

  // Pipeline capture: data always advances, controls squashed on a bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pc_plus4_o        <= '0;
      rs_data_o         <= '0;
      rt_data_o         <= '0;
      immed_o           <= '0;
      rs_addr_o         <= '0;
      rt_addr_o         <= '0;
      reg_write_addr_o  <= '0;
      reg_write_ctrl_o  <= 1'b0;
      mem_read_ctrl_o   <= 1'b0;
      mem_write_ctrl_o  <= 1'b0;
      mem_to_reg_ctrl_o <= 1'b0;
      alu_src_ctrl_o    <= 1'b0;
      alu_op_ctrl_o     <= '0;
      valid_o           <= 1'b0;
    end else begin
      pc_plus4_o <= pc_plus4_i;
      rs_data_o  <= rs_data_i;
      rt_data_o  <= rt_data_i;
      immed_o    <= immed_i;
      rs_addr_o  <= rs_addr_i;
      rt_addr_o  <= rt_addr_i;
      if (bubble) begin
        reg_write_addr_o  <= '0;
        reg_write_ctrl_o  <= 1'b0;
        mem_read_ctrl_o   <= 1'b0;
        mem_write_ctrl_o  <= 1'b0;
        mem_to_reg_ctrl_o <= 1'b0;
        alu_src_ctrl_o    <= 1'b0;
        alu_op_ctrl_o     <= '0;
        valid_o           <= 1'b0;
      end else begin
        // Writes/loads targeting $0 are dropped so they never look like hazards
        reg_write_addr_o  <= dest;
        reg_write_ctrl_o  <= reg_write_ctrl_i & ~dest_is_zero;
        mem_read_ctrl_o   <= mem_read_ctrl_i & ~dest_is_zero;
        mem_write_ctrl_o  <= mem_write_ctrl_i;
        mem_to_reg_ctrl_o <= mem_to_reg_ctrl_i;
        alu_src_ctrl_o    <= alu_src_ctrl_i;
        alu_op_ctrl_o     <= alu_op_ctrl_i;
        valid_o           <= 1'b1;
      end
    end
  end

  // Saturating bubble counter; clear wins over a concurrent bubble
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bubble_cnt_o <= '0;
    end else if (cnt_clr_i) begin
      bubble_cnt_o <= '0;
    end else if (bubble && (bubble_cnt_o != CNT_MAX)) begin
      bubble_cnt_o <= bubble_cnt_o + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_id_to_ex_register.sv
// Self-checking bench for id_to_ex_register: a reference model pushes the
// expected EX-stage contents per driven cycle; they are popped after the edge.
module tb_id_to_ex_register;

  localparam int unsigned CW = 4;

  logic clk, rst, stall, flush, cnt_clr;
  logic [31:0] pc_plus4, rs_data, rt_data, immed;
  logic [4:0]  rs_addr, rt_addr, rd_addr;
  logic reg_dst, reg_write, mem_read, mem_write, mem_to_reg, alu_src;
  logic [2:0]  alu_op;

  logic [31:0] o_pc, o_rs, o_rt, o_imm;
  logic [4:0]  o_rsa, o_rta, o_wa;
  logic o_rw, o_mr, o_mw, o_m2r, o_as, o_v;
  logic [2:0]  o_op;
  logic [CW-1:0] o_cnt;

  typedef struct packed {
    logic [31:0] pc, rs, rt, imm;
    logic [4:0]  rsa, rta, wa;
    logic rw, mr, mw, m2r, as;
    logic [2:0]  op;
    logic v;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t exp_q[$];
  logic [CW-1:0] m_cnt;
  int checks = 0;
  int errors = 0;

  id_to_ex_register #(.CNT_WIDTH(CW)) dut (
    .clk_i(clk), .rst_i(rst), .stall_ctrl_i(stall), .flush_ctrl_i(flush),
    .cnt_clr_i(cnt_clr), .pc_plus4_i(pc_plus4), .rs_data_i(rs_data),
    .rt_data_i(rt_data), .immed_i(immed), .rs_addr_i(rs_addr),
    .rt_addr_i(rt_addr), .rd_addr_i(rd_addr), .reg_dst_ctrl_i(reg_dst),
    .reg_write_ctrl_i(reg_write), .mem_read_ctrl_i(mem_read),
    .mem_write_ctrl_i(mem_write), .mem_to_reg_ctrl_i(mem_to_reg),
    .alu_src_ctrl_i(alu_src), .alu_op_ctrl_i(alu_op),
    .pc_plus4_o(o_pc), .rs_data_o(o_rs), .rt_data_o(o_rt), .immed_o(o_imm),
    .rs_addr_o(o_rsa), .rt_addr_o(o_rta), .reg_write_addr_o(o_wa),
    .reg_write_ctrl_o(o_rw), .mem_read_ctrl_o(o_mr), .mem_write_ctrl_o(o_mw),
    .mem_to_reg_ctrl_o(o_m2r), .alu_src_ctrl_o(o_as), .alu_op_ctrl_o(o_op),
    .valid_o(o_v), .bubble_cnt_o(o_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference model of one capture, using the current inputs
  function automatic exp_t model();
    exp_t e;
    logic [4:0] dest;
    logic bub;
    dest = reg_dst ? rd_addr : rt_addr;
    bub  = stall | flush;
    e.pc = pc_plus4; e.rs = rs_data; e.rt = rt_data; e.imm = immed;
    e.rsa = rs_addr; e.rta = rt_addr;
    if (bub) begin
      e.wa = 5'd0; e.rw = 1'b0; e.mr = 1'b0; e.mw = 1'b0; e.m2r = 1'b0;
      e.as = 1'b0; e.op = 3'd0; e.v = 1'b0;
    end else begin
      e.wa = dest;
      e.rw = reg_write && (dest != 5'd0);
      e.mr = mem_read && (dest != 5'd0);
      e.mw = mem_write; e.m2r = mem_to_reg; e.as = alu_src; e.op = alu_op;
      e.v = 1'b1;
    end
    if (cnt_clr) m_cnt = '0;
    else if (bub && (m_cnt != {CW{1'b1}})) m_cnt = m_cnt + CW'(1);
    e.cnt = m_cnt;
    return e;
  endfunction

  task automatic compare(input exp_t e);
    check("pc_plus4", o_pc, e.pc);
    check("rs_data", o_rs, e.rs);
    check("rt_data", o_rt, e.rt);
    check("immed", o_imm, e.imm);
    check("rs_addr", 32'(o_rsa), 32'(e.rsa));
    check("rt_addr", 32'(o_rta), 32'(e.rta));
    check("wr_addr", 32'(o_wa), 32'(e.wa));
    check("reg_write", 32'(o_rw), 32'(e.rw));
    check("mem_read", 32'(o_mr), 32'(e.mr));
    check("mem_write", 32'(o_mw), 32'(e.mw));
    check("mem_to_reg", 32'(o_m2r), 32'(e.m2r));
    check("alu_src", 32'(o_as), 32'(e.as));
    check("alu_op", 32'(o_op), 32'(e.op));
    check("valid", 32'(o_v), 32'(e.v));
    check("bubble_cnt", 32'(o_cnt), 32'(e.cnt));
  endtask

  // Drive one cycle: push the model's expectation, clock, pop and compare
  task automatic step();
    exp_t e;
    exp_q.push_back(model());
    @(posedge clk);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      compare(e);
    end
  endtask

  task automatic check_reset_zero();
    exp_t z;
    z = '0;
    compare(z);
  endtask

  task automatic set_instr(input logic [31:0] pc, input logic [31:0] rsd,
                           input logic [31:0] rtd, input logic [31:0] imm,
                           input logic [4:0] rsa, input logic [4:0] rta,
                           input logic [4:0] rda, input logic rdst,
                           input logic rw, input logic mr, input logic mw,
                           input logic m2r, input logic as, input logic [2:0] op);
    pc_plus4 = pc; rs_data = rsd; rt_data = rtd; immed = imm;
    rs_addr = rsa; rt_addr = rta; rd_addr = rda; reg_dst = rdst;
    reg_write = rw; mem_read = mr; mem_write = mw; mem_to_reg = m2r;
    alu_src = as; alu_op = op;
  endtask

  task automatic rand_instr();
    set_instr($urandom, $urandom, $urandom, $urandom, 5'($urandom),
              5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              3'($urandom));
  endtask

  initial begin
    m_cnt = '0;
    stall = 1'b1; flush = 1'b1; cnt_clr = 1'b1;
    set_instr(32'hFFFF_FFFF, 32'hA5A5_A5A5, 32'h5A5A_5A5A, 32'h1111_2222,
              5'd31, 5'd30, 5'd29, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd7);
    rst = 1'b1;
    #2;
    check_reset_zero();
    stall = 1'b0; flush = 1'b0; cnt_clr = 1'b0;
    #1 rst = 1'b0;

    // Normal capture, rd then rt destination
    set_instr(32'h0000_0104, 32'h0000_1234, 32'h0000_0042, 32'h0000_0010,
              5'd3, 5'd7, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010);
    step();
    check("norm_wa_rd", 32'(o_wa), 32'd5);
    reg_dst = 1'b0;
    step();
    check("norm_wa_rt", 32'(o_wa), 32'd7);

    // Load, then a stalled dependent instruction, then its real capture
    set_instr(32'h0000_0200, 32'h0, 32'h0, 32'h4, 5'd2, 5'd9, 5'd0,
              1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd0);
    step();
    check("load_mr", 32'(o_mr), 32'd1);
    set_instr(32'h0000_0204, 32'h77, 32'h88, 32'h0, 5'd9, 5'd4, 5'd6,
              1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1);
    stall = 1'b1;
    step();
    check("stall_cnt", 32'(o_cnt), 32'd1);
    stall = 1'b0;
    step();
    check("dep_valid", 32'(o_v), 32'd1);

    // $0 destination drops write and load controls
    set_instr(32'h0000_0300, 32'h1, 32'h2, 32'h3, 5'd1, 5'd0, 5'd8,
              1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 3'd4);
    step();
    check("zero_rw", 32'(o_rw), 32'd0);

    for (int i = 0; i < 10; i++) begin
      rand_instr();
      step();
    end

    // Stall and flush together count as one bubble per cycle
    stall = 1'b1; flush = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_instr();
      step();
    end
    check("sf_cnt", 32'(o_cnt), 32'd4);
    stall = 1'b0;
    step();
    flush = 1'b0;

    // Saturation
    stall = 1'b1;
    for (int i = 0; i < 20; i++) begin
      rand_instr();
      step();
    end
    check("sat_cnt", 32'(o_cnt), 32'd15);
    cnt_clr = 1'b1;
    step();
    check("clr_cnt", 32'(o_cnt), 32'd0);
    cnt_clr = 1'b0;
    step();
    check("post_clr_cnt", 32'(o_cnt), 32'd1);
    stall = 1'b0;
    cnt_clr = 1'b1;
    rand_instr();
    step();
    cnt_clr = 1'b0;

    // Mid-operation reset clears outputs without a clock edge
    stall = 1'b1;
    step();
    set_instr(32'hDEAD_BEEF, 32'h1, 32'h2, 32'h3, 5'd1, 5'd2, 5'd3,
              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 3'd5);
    stall = 1'b0;
    #1 rst = 1'b1;
    #1;
    check_reset_zero();
    m_cnt = '0;
    #1 rst = 1'b0;
    step();
    check("post_rst_valid", 32'(o_v), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
